// File: rtl/hazard_scoreboard_if.sv
// Hazard scoreboard bus interface.
// Groups every pipeline-side signal of the hazard unit into one bundle:
//   slave  : seen from the hazard unit (pipeline status in, stall/forward out)
//   master : seen from the pipeline / testbench driving the hazard unit
// Parameter REG_AW is the register-specifier width.
interface hazard_scoreboard_if #(
  parameter int REG_AW = 5
);
  logic              RFWEE, RFWEM, RFWEW;
  logic              MtoRFSelE, MtoRFSelM;
  logic              BranchD;
  logic              MDOpD, MDStartE;
  logic [REG_AW-1:0] rsD, rtD, rsE, rtE, rtdE, rtdM, rtdW;

  logic              LWStall, BRStall, MDStall;
  logic              StallF, StallD, FlushE;
  logic [1:0]        ForwardAE, ForwardBE;
  logic              ForwardAD, ForwardBD;
  logic              MDDone;
  logic [REG_AW-1:0] MDDest;
  logic [31:0]       StallCnt;

  modport slave (
    input  RFWEE, RFWEM, RFWEW, MtoRFSelE, MtoRFSelM, BranchD, MDOpD, MDStartE,
           rsD, rtD, rsE, rtE, rtdE, rtdM, rtdW,
    output LWStall, BRStall, MDStall, StallF, StallD, FlushE,
           ForwardAE, ForwardBE, ForwardAD, ForwardBD, MDDone, MDDest, StallCnt
  );

  modport master (
    output RFWEE, RFWEM, RFWEW, MtoRFSelE, MtoRFSelM, BranchD, MDOpD, MDStartE,
           rsD, rtD, rsE, rtE, rtdE, rtdM, rtdW,
    input  LWStall, BRStall, MDStall, StallF, StallD, FlushE,
           ForwardAE, ForwardBE, ForwardAD, ForwardBD, MDDone, MDDest, StallCnt
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Hazard unit for a 5-stage pipeline with a multi-cycle (mult/div) scoreboard.
// Produces forwarding selects, load-use / branch / multi-cycle stall causes and
// the combined StallF/StallD/FlushE controls.
// Ports:
//   CLK  - clock, all state updates on rising edge
//   RST  - synchronous active-low reset
//   hz   - hazard_scoreboard_if.slave bundle (pipeline status in, controls out)
// Parameters: REG_AW (specifier width), MD_LAT (multi-cycle latency, 2..15).
// Optional feature: define HAZARD_SCOREBOARD_PERF_CNT_EN to build a saturating
// stall-cycle counter on StallCnt; otherwise StallCnt is tied to 0.
//
// Multi-cycle scoreboard states:
//   state | meaning
//   IDLE  | no multi-cycle op outstanding
//   BUSY  | op in flight, cnt counts down to the last busy cycle
//   DONE  | result valid this cycle (MDDone=1), one cycle only
module hazard_scoreboard #(
  parameter int REG_AW = 5,
  parameter int MD_LAT = 4
) (
  input logic               CLK,
  input logic               RST,
  hazard_scoreboard_if.slave hz
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  localparam logic [3:0] MD_LOAD = 4'(MD_LAT - 1);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [REG_AW-1:0] dest_q, dest_d;

  logic lw_stall, br_stall, md_stall, stall;
  logic rs_d_nz, rt_d_nz, rs_e_nz, rt_e_nz, rtd_e_nz, rtd_m_nz, dest_nz;

  assign rs_d_nz  = (hz.rsD  != '0);
  assign rt_d_nz  = (hz.rtD  != '0);
  assign rs_e_nz  = (hz.rsE  != '0);
  assign rt_e_nz  = (hz.rtE  != '0);
  assign rtd_e_nz = (hz.rtdE != '0);
  assign rtd_m_nz = (hz.rtdM != '0);
  assign dest_nz  = (dest_q  != '0);

  // Forwarding: memory stage takes priority over writeback (newer value).
  always_comb begin
    hz.ForwardAE = 2'b00;
    hz.ForwardBE = 2'b00;
    if (rs_e_nz && hz.RFWEM && hz.rsE == hz.rtdM)      hz.ForwardAE = 2'b10;
    else if (rs_e_nz && hz.RFWEW && hz.rsE == hz.rtdW) hz.ForwardAE = 2'b01;
    if (rt_e_nz && hz.RFWEM && hz.rtE == hz.rtdM)      hz.ForwardBE = 2'b10;
    else if (rt_e_nz && hz.RFWEW && hz.rtE == hz.rtdW) hz.ForwardBE = 2'b01;
  end

  assign hz.ForwardAD = rs_d_nz && hz.RFWEM && (hz.rsD == hz.rtdM);
  assign hz.ForwardBD = rt_d_nz && hz.RFWEM && (hz.rtD == hz.rtdM);

  assign lw_stall = hz.MtoRFSelE && rt_e_nz && (hz.rtE == hz.rsD || hz.rtE == hz.rtD);

  // Branches resolve in Decode, so an ALU result still in E or a load in M
  // cannot be forwarded in time.
  assign br_stall = hz.BranchD &&
                    ((hz.RFWEE && rtd_e_nz && (hz.rsD == hz.rtdE || hz.rtD == hz.rtdE)) ||
                     (hz.MtoRFSelM && rtd_m_nz && (hz.rsD == hz.rtdM || hz.rtD == hz.rtdM)));

  // Stall readers of the pending destination until the result is written,
  // block a second multi-cycle op while one is in flight, and cover the
  // issue cycle before the scoreboard has captured rtdE.
  assign md_stall = (((state_q == BUSY) || (state_q == DONE)) && dest_nz &&
                     (hz.rsD == dest_q || hz.rtD == dest_q)) ||
                    ((state_q == BUSY) && hz.MDOpD) ||
                    (hz.MDStartE && (hz.MDOpD ||
                     (rtd_e_nz && (hz.rsD == hz.rtdE || hz.rtD == hz.rtdE))));

  assign stall      = lw_stall || br_stall || md_stall;
  assign hz.LWStall = lw_stall;
  assign hz.BRStall = br_stall;
  assign hz.MDStall = md_stall;
  assign hz.StallF  = stall;
  assign hz.StallD  = stall;
  assign hz.FlushE  = stall;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dest_d  = dest_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (hz.MDStartE) begin
          state_d = BUSY;
          cnt_d   = MD_LOAD;
          dest_d  = hz.rtdE;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dest_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dest_q  <= dest_d;
    end
  end

  assign hz.MDDone = (state_q == DONE);
  assign hz.MDDest = dest_q;

`ifdef HAZARD_SCOREBOARD_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && stall_cnt_q != 32'hFFFF_FFFF) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge CLK) begin
    if (!RST) stall_cnt_q <= '0;
    else      stall_cnt_q <= stall_cnt_d;
  end

  assign hz.StallCnt = stall_cnt_q;
`else
  assign hz.StallCnt = '0;
`endif

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 Parameter REG_AW, default 5: register-specifier width; all rs/rt/rtd ports SHALL be REG_AW bits wide.
REQ-002 Parameter MD_LAT, default 4: multi-cycle (mult/div) result latency in cycles; legal range 2..15.
REQ-003 CLK  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 RST  input  1  reset, synchronous and active-low.
REQ-005 RFWEE, RFWEM, RFWEW  input  1 each  register-file write enables for E, M, W.
REQ-006 MtoRFSelE, MtoRFSelM  input  1 each  load (memory-to-RF) select for E, M.
REQ-007 BranchD  input  1  branch in Decode.
REQ-008 MDOpD  input  1  multi-cycle op in Decode; MDStartE  input  1  multi-cycle op issuing from Execute to destination rtdE.
REQ-009 rsD, rtD, rsE, rtE, rtdE, rtdM, rtdW  input  REG_AW each  source/destination specifiers.
REQ-010 LWStall, BRStall, MDStall  output  1 each  stall causes.
REQ-011 StallF, StallD, FlushE  output  1 each  pipeline controls.
REQ-012 ForwardAE, ForwardBE  output  2 each; ForwardAD, ForwardBD  output  1 each  forwarding selects.
REQ-013 MDDone  output  1  multi-cycle result valid this cycle; MDDest  output  REG_AW  its destination.
REQ-014 StallCnt  output  32  stall-cycle counter.

Function
REQ-015 ForwardAE SHALL be 2'b10 if rsE!=0 & RFWEM & rsE==rtdM, else 2'b01 if rsE!=0 & RFWEW & rsE==rtdW, else 2'b00; ForwardBE identically on rtE (M priority over W).
REQ-016 ForwardAD SHALL be 1 iff rsD!=0 & RFWEM & rsD==rtdM; ForwardBD identically on rtD.
REQ-017 LWStall SHALL be 1 iff MtoRFSelE & rtE!=0 & (rtE==rsD | rtE==rtD).
REQ-018 BRStall SHALL be 1 iff BranchD & ((RFWEE & rtdE!=0 & (rsD==rtdE | rtD==rtdE)) | (MtoRFSelM & rtdM!=0 & (rsD==rtdM | rtD==rtdM))).
REQ-019 Scoreboard FSM states IDLE, BUSY, DONE; registers state, cnt (4 bits), dest (REG_AW).
REQ-020 In IDLE or DONE, MDStartE=1 SHALL load state<=BUSY, cnt<=MD_LAT-1, dest<=rtdE (DONE->BUSY back-to-back allowed).
REQ-021 In BUSY: cnt==1 SHALL go to DONE; otherwise cnt<=cnt-1; MDStartE in BUSY SHALL be ignored (prevented by REQ-024).
REQ-022 DONE with MDStartE=0 SHALL go to IDLE; DONE lasts exactly one cycle.
REQ-023 MDDone SHALL be 1 exactly in DONE; MDDest SHALL equal dest at all times.
REQ-024 MDStall SHALL be 1 iff (state in {BUSY,DONE} & dest!=0 & (rsD==dest | rtD==dest)) | (state==BUSY & MDOpD) | (MDStartE & (MDOpD | (rtdE!=0 & (rsD==rtdE | rtD==rtdE)))).
REQ-025 StallF = StallD = FlushE = LWStall | BRStall | MDStall, combinational, same cycle.
REQ-026 Zero register: no stall or forward SHALL arise from a specifier of 0.
REQ-027 All outputs except StallCnt, MDDone, MDDest SHALL be combinational from current inputs and state.

Reset
REQ-028 RST=0 at a rising edge SHALL set state=IDLE, cnt=0, dest=0, StallCnt=0; takes priority over all other updates.
REQ-029 Reset mid-operation SHALL abandon the pending op; MDDone SHALL NOT assert for it.
REQ-030 After reset with all inputs 0, every output SHALL be 0.

Configuration
REQ-031 Macro HAZARD_SCOREBOARD_PERF_CNT_EN defined: StallCnt SHALL increment by 1 on every rising edge where StallD=1 (outside reset), saturating at 32'hFFFFFFFF.
REQ-032 Macro undefined: StallCnt SHALL be constant 0 and no counter register SHALL exist.

Verification
REQ-033 rsE=3, RFWEM=1, rtdM=3, RFWEW=1, rtdW=3 -> ForwardAE=2'b10; then RFWEM=0 -> 2'b01; rsE=0 -> 2'b00.
REQ-034 MtoRFSelE=1, rtE=5, rsD=5 -> LWStall=StallF=StallD=FlushE=1; rtE=0 -> all 0.
REQ-035 MD_LAT=4, MDStartE=1, rtdE=7 at edge 0 -> BUSY cycles 1-3, MDDone=1 and MDDest=7 cycle 4, IDLE cycle 5; rsD=7 held -> MDStall=1 cycles 0-4, 0 cycle 5.
REQ-036 BUSY with MDOpD=1 -> MDStall=1; MDStartE at DONE cycle -> re-enters BUSY with cnt=3, no IDLE cycle.
REQ-037 RST=0 during BUSY cycle 2 -> IDLE next cycle, MDDone never asserts, MDStall=0.
REQ-038 PERF_CNT_EN defined, StallD held 1 for 10 cycles -> StallCnt=10; undefined -> StallCnt=0.
